// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM stream front-end: op codes, tuser field
// positions, instruction flag bits and the loader state encoding.
package mvm_pkg;

    // Command / tuser op field encodings
    localparam logic [1:0] OP_INSTR = 2'b00;
    localparam logic [1:0] OP_RED   = 2'b01;
    localparam logic [1:0] OP_INVEC = 2'b10;
    localparam logic [1:0] OP_RFW   = 2'b11;

    // Position of the 2-bit op field inside tuser
    localparam int TUSER_OP_LSB = 9;

    // Default position of the RF one-hot select inside tuser
    localparam int RF_BASE_DEFAULT = 11;

    // Instruction word flag bits
    localparam int INSTR_RDC = 0;
    localparam int INSTR_ACM = 1;
    localparam int INSTR_RLS = 2;
    localparam int INSTR_LST = 3;

    // Loader sequencing states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/mvm_tuser_enc.sv
// Combinational tuser builder: node field, op field and (for RF writes) a
// one-hot register-file select. USERW must cover RF_BASE + NUM_RF bits.
module mvm_tuser_enc
    import mvm_pkg::*;
#(
    parameter int USERW   = 75,
    parameter int NODESW  = 9,
    parameter int RF_BASE = RF_BASE_DEFAULT,
    parameter int NUM_RF  = 64,
    parameter int RFIW    = $clog2(NUM_RF)
) (
    input  logic [1:0]        op,
    input  logic [NODESW-1:0] node,
    input  logic [RFIW-1:0]   rf_idx,
    output logic [USERW-1:0]  tuser
);

    logic [NUM_RF-1:0] rf_sel;

    // One-hot RF select, only meaningful for RF writes
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        rf_sel = '0;
        if (op == OP_RFW) begin
            rf_sel[rf_idx] = 1'b1;
        end
    end

    // Pack node, op and RF select; all other tuser bits stay zero
    always_comb begin
        tuser                        = '0;
        tuser[NODESW-1:0]            = node;
        tuser[TUSER_OP_LSB +: 2]     = op;
        tuser[RF_BASE +: NUM_RF]     = rf_sel;
    end

endmodule

// File: rtl/mvm_axis_loader.sv
// Turns host burst commands plus payload beats into fully formed MVM
// AXI-Stream beats (tdata/tuser/tlast) through a single output register,
// and tracks how many released results are still outstanding.
module mvm_axis_loader
    import mvm_pkg::*;
#(
    parameter int DATAW   = 512,
    parameter int USERW   = 75,
    parameter int NODESW  = 9,
    parameter int RF_BASE = RF_BASE_DEFAULT,
    parameter int NUM_RF  = 64,
    parameter int LENW    = 8,
    parameter int PENDW   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [NODESW-1:0]          cmd_node,
    input  logic [$clog2(NUM_RF)-1:0]  cmd_rf_first,
    input  logic [LENW-1:0]            cmd_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATAW-1:0]           in_data,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATAW-1:0]           m_axis_tdata,
    output logic [USERW-1:0]           m_axis_tuser,
    output logic                       m_axis_tlast,
    input  logic                       res_seen,
    output logic                       busy,
    output logic [PENDW-1:0]           pending,
    output logic                       err_underflow
);

    localparam int RFIW = $clog2(NUM_RF);
    localparam logic [0:0] IDLE  = ST_IDLE;
    localparam logic [0:0] BURST = ST_BURST;

    logic [0:0]        state_q;
    logic [1:0]        op_q;
    logic [NODESW-1:0] node_q;
    logic [RFIW-1:0]   rf_idx_q;
    logic [LENW-1:0]   len_q;
    logic [LENW-1:0]   beat_q;

    logic              tvalid_q;
    logic [DATAW-1:0]  tdata_q;
    logic [USERW-1:0]  tuser_q;
    logic [USERW-1:0]  tuser_next;

    logic [PENDW-1:0]  pending_q;
    logic              err_q;

    logic              cmd_hs;
    logic              in_hs;
    logic              last_beat;
    logic              rls_accept;

    // Payload is taken whenever the output register is empty or draining
    assign cmd_ready = (state_q == IDLE);
    assign in_ready  = (state_q == BURST) && (!tvalid_q || m_axis_tready);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign in_hs     = in_valid && in_ready;
    assign last_beat = (beat_q == len_q);

    mvm_tuser_enc #(
        .USERW   (USERW),
        .NODESW  (NODESW),
        .RF_BASE (RF_BASE),
        .NUM_RF  (NUM_RF),
        .RFIW    (RFIW)
    ) u_tuser_enc (
        .op     (op_q),
        .node   (node_q),
        .rf_idx (rf_idx_q),
        .tuser  (tuser_next)
    );

    // Command latch, beat counting, RF index walk and burst termination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
            state_q  <= IDLE;
            op_q     <= OP_INSTR;
            node_q   <= '0;
            rf_idx_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
        end else if (state_q == IDLE) begin
            if (cmd_hs) begin
                op_q     <= cmd_op;
                node_q   <= cmd_node;
                rf_idx_q <= cmd_rf_first;
                len_q    <= cmd_len;
                beat_q   <= '0;
                state_q  <= BURST;
            end
        end else if (in_hs) begin
            beat_q <= beat_q + LENW'(1);
            if (op_q == OP_RFW) begin
                rf_idx_q <= (rf_idx_q == RFIW'(NUM_RF - 1)) ? '0 : rf_idx_q + RFIW'(1);
            end
            if (last_beat) begin
                state_q <= IDLE;
            end
        end
    end

    // Output register: load on payload accept, hold while stalled, clear valid on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data/user registers are reset too because their reset value is visible on the port.
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= '0;
        end else if (in_hs) begin
            tvalid_q <= 1'b1;
            tdata_q  <= in_data;
            tuser_q  <= tuser_next;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    // An instruction with RLS set that reaches the MVM will release one result
    assign rls_accept = tvalid_q && m_axis_tready
                     && (tuser_q[TUSER_OP_LSB +: 2] == OP_INSTR)
                     && tdata_q[INSTR_RLS];

    // Outstanding-result counter with saturation and sticky underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else if (rls_accept && !res_seen) begin
            if (pending_q != '1) begin
                pending_q <= pending_q + PENDW'(1);
            end
        end else if (res_seen && !rls_accept) begin
            if (pending_q == '0) begin
                err_q <= 1'b1;
            end else begin
                pending_q <= pending_q - PENDW'(1);
            end
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tvalid_q;
    assign busy          = (state_q != IDLE) || tvalid_q;
    assign pending       = pending_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_mvm_axis_loader.sv
// Self-checking bench for mvm_axis_loader: table of directed bursts,
// hand-written stall / underflow / reset sequences and randomized bursts,
// all compared against an expected-beat queue and a pending-count model.
module tb_mvm_axis_loader;
    import mvm_pkg::*;

    localparam int DATAW  = 512;
    localparam int USERW  = 75;
    localparam int NODESW = 9;
    localparam int RFB    = 11;
    localparam int NUM_RF = 64;
    localparam int LENW   = 8;
    localparam int PENDW  = 8;
    localparam int RFIW   = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [NODESW-1:0] cmd_node = '0;
    logic [RFIW-1:0]   cmd_rf_first = '0;
    logic [LENW-1:0]   cmd_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATAW-1:0]  in_data = '0;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic [DATAW-1:0]  m_axis_tdata;
    logic [USERW-1:0]  m_axis_tuser;
    logic              m_axis_tlast;
    logic              res_seen = 1'b0;
    logic              busy;
    logic [PENDW-1:0]  pending;
    logic              err_underflow;

    mvm_axis_loader #(
        .DATAW(DATAW), .USERW(USERW), .NODESW(NODESW), .RF_BASE(RFB),
        .NUM_RF(NUM_RF), .LENW(LENW), .PENDW(PENDW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_node(cmd_node), .cmd_rf_first(cmd_rf_first), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .res_seen(res_seen), .busy(busy),
        .pending(pending), .err_underflow(err_underflow)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_to(input string name);
        n_checks++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Reference model: expected beats in order, pending count, sticky error
    typedef struct packed {
        logic [DATAW-1:0] d;
        logic [USERW-1:0] u;
    } beat_t;

    beat_t            exp_q[$];
    int               m_pend = 0;
    bit               m_err  = 1'b0;
    int               beats_seen = 0;
    logic [USERW-1:0] first_u = '0;
    bit               rdy_rand = 1'b0;

    function automatic logic [USERW-1:0] model_tuser(input logic [1:0] op, input logic [NODESW-1:0] node, input int rf);
        logic [USERW-1:0] u;
        u = USERW'(node) | (USERW'(op) << 9);
        if (op == 2'b11) u = u | (USERW'(1) << (RFB + rf));
        return u;
    endfunction

    // Random back-pressure when enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) m_axis_tready = ($urandom_range(0, 3) != 0);
    end

    // Monitor, sampled mid-cycle: beat order/content, hold-while-stalled, pending model
    bit               held_v = 1'b0;
    logic [DATAW-1:0] held_d;
    logic [USERW-1:0] held_u;
    always @(negedge clk) begin
        beat_t b;
        bit    inc;
        if (!rst_n) begin
            exp_q.delete();
            m_pend = 0;
            m_err  = 1'b0;
            held_v = 1'b0;
            check("pending_rst", pending, 0);
        end else begin
            if (held_v && m_axis_tvalid)
                check("hold_stable", {m_axis_tuser, m_axis_tdata}, {held_u, held_d});
            held_v = m_axis_tvalid && !m_axis_tready;
            held_d = m_axis_tdata;
            held_u = m_axis_tuser;
            check("pending", pending, PENDW'(m_pend));
            check("err_underflow", err_underflow, m_err);
            inc = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                check("tlast", m_axis_tlast, 1'b1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_beat: got tuser %0h expected no beat", m_axis_tuser);
                end else begin
                    b = exp_q.pop_front();
                    check("beat", {m_axis_tuser, m_axis_tdata}, {b.u, b.d});
                    inc = (b.u[10:9] == 2'b00) && b.d[2];
                end
                if (beats_seen == 0) first_u = m_axis_tuser;
                beats_seen++;
            end
            if (inc && !res_seen) begin
                if (m_pend < 255) m_pend++;
            end else if (res_seen && !inc) begin
                if (m_pend == 0) m_err = 1'b1;
                else m_pend--;
            end
        end
    end

    // Issue one command and its payloads; pat: -1 random, -2 RLS instruction word, else byte fill
    task automatic run_burst(input logic [1:0] op, input logic [NODESW-1:0] node, input int rf_first,
                             input int len, input int pat, input bit gaps, input int abort_at);
        int               t;
        bit               hs;
        logic [DATAW-1:0] d;
        logic [7:0]       fill;
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_node     = node;
        cmd_rf_first = RFIW'(rf_first);
        cmd_len      = LENW'(len);
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 100) begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk);
            #1;
            t++;
        end
        cmd_valid = 1'b0;
        if (!hs) begin
            fail_to("cmd_accept");
            return;
        end
        for (int i = 0; i <= len; i++) begin
            if (pat == -1) begin
                for (int k = 0; k < DATAW / 32; k++) d[k*32 +: 32] = $urandom;
            end else if (pat == -2) begin
                d = DATAW'(32'h8000200E);
            end else begin
                fill = 8'(pat);
                d = {(DATAW / 8){fill}};
            end
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = d;
            t  = 0;
            hs = 1'b0;
            while (!hs && t < 200) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!hs) begin
                in_valid = 1'b0;
                fail_to("payload_accept");
                return;
            end
            exp_q.push_back('{d: d, u: model_tuser(op, node, (rf_first + i) % NUM_RF)});
            if (abort_at == i + 1) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) fail_to(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        check({tag, "_tdata"}, m_axis_tdata, '0);
        check({tag, "_tuser"}, m_axis_tuser, '0);
        check({tag, "_tlast"}, m_axis_tlast, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pending"}, pending, '0);
        check({tag, "_err"}, err_underflow, 1'b0);
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [NODESW-1:0] node;
        int                rf_first;
        int                len;
        int                pat;
        bit                rnd;
        int                exp_beats;
        logic [USERW-1:0]  exp_first_u;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'b11, 9'h001, 0,  63, -1, 1'b0, 64, 75'hE01};
        vecs[1] = '{2'b11, 9'h001, 62, 3,  -1, 1'b0, 4,  (75'd1 << 73) | 75'h601};
        vecs[2] = '{2'b10, 9'h005, 0,  3,  1,  1'b0, 4,  75'h405};
        vecs[3] = '{2'b01, 9'h005, 0,  3,  2,  1'b0, 4,  75'h205};
        vecs[4] = '{2'b00, 9'h1FF, 0,  0,  -2, 1'b0, 1,  75'h1FF};
        vecs[5] = '{2'b11, 9'h0A5, 5,  7,  -1, 1'b1, 8,  75'h6A5 | (75'd1 << 16)};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed bursts from the table
        for (int v = 0; v < 6; v++) begin
            beats_seen    = 0;
            rdy_rand      = vecs[v].rnd;
            m_axis_tready = 1'b1;
            run_burst(vecs[v].op, vecs[v].node, vecs[v].rf_first, vecs[v].len, vecs[v].pat, 1'b0, -1);
            drain("vec_drain");
            rdy_rand      = 1'b0;
            m_axis_tready = 1'b1;
            @(posedge clk);
            #1;
            check("vec_beats", beats_seen, vecs[v].exp_beats);
            check("vec_first_tuser", first_u, vecs[v].exp_first_u);
            check("vec_idle_cmd_ready", cmd_ready, 1'b1);
            check("vec_idle_busy", busy, 1'b0);
            if (v == 4) check("rls_pending", pending, 1);
        end

        // Result release then an extra release at zero
        res_seen = 1'b1;
        @(posedge clk);
        #1;
        res_seen = 1'b0;
        check("res_dec_pending", pending, 0);
        check("res_dec_err", err_underflow, 1'b0);
        res_seen = 1'b1;
        @(posedge clk);
        #1;
        res_seen = 1'b0;
        check("underflow_pending", pending, 0);
        check("underflow_err", err_underflow, 1'b1);

        // Back-pressure 1,0,0,1 during a 4-beat burst
        beats_seen    = 0;
        m_axis_tready = 1'b1;
        fork
            run_burst(2'b10, 9'h003, 0, 3, -1, 1'b0, -1);
            begin
                int t = 0;
                while (!m_axis_tvalid && t < 50) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                m_axis_tready = 1'b1;
                @(posedge clk); #1; m_axis_tready = 1'b0;
                @(posedge clk); #1; m_axis_tready = 1'b0;
                @(posedge clk); #1; m_axis_tready = 1'b1;
            end
        join
        drain("stall_drain");
        check("stall_beats", beats_seen, 4);

        // Randomized bursts and result releases
        rdy_rand = 1'b1;
        for (int r = 0; r < 20; r++) begin
            run_burst(2'($urandom_range(0, 3)), NODESW'($urandom), $urandom_range(0, NUM_RF - 1),
                      $urandom_range(0, 15), -1, 1'b1, -1);
            if ($urandom_range(0, 1) == 1) begin
                res_seen = 1'b1;
                @(posedge clk);
                #1;
                res_seen = 1'b0;
            end
        end
        drain("rand_drain");
        rdy_rand      = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;

        // Reset after beat 2 of an 8-beat burst, then a clean burst
        run_burst(2'b10, 9'h007, 0, 7, -1, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beats_seen = 0;
        run_burst(2'b11, 9'h002, 10, 2, -1, 1'b0, -1);
        drain("post_reset_drain");
        @(posedge clk);
        #1;
        check("post_reset_beats", beats_seen, 3);
        check("post_reset_first_tuser", first_u, 75'h602 | (75'd1 << 21));
        check("post_reset_idle", cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mvm_axis_loader.md
# mvm_axis_loader

Sequencer between a host command/data stream and the `rtl_mvm` AXI-Stream receive port. It turns burst commands into fully formed MVM beats: RF weight writes with walking one-hot register-file select, input vectors, reduction vectors and instructions. It also tracks outstanding results released by the MVM. It replaces hand-built `tuser` sequencing and generalises it in RF count, burst length and node addressing.

## Interface
- `DATAW`, 512, beat width
- `USERW`, 75, `tuser` width; must be at least `RF_BASE + NUM_RF`
- `NODESW`, 9, node/RF-address field width, `tuser[NODESW-1:0]`
- `RF_BASE`, 11, bit position of the RF one-hot select in `tuser`
- `NUM_RF`, 64, register files per MVM; select field is `tuser[RF_BASE+NUM_RF-1:RF_BASE]`
- `LENW`, 8, burst length field width
- `PENDW`, 8, outstanding-result counter width
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake
- `cmd_op`  in  2  00 instr, 01 reduction vec, 10 input vec, 11 RF write
- `cmd_node`  in  NODESW  value placed in `tuser[NODESW-1:0]`
- `cmd_rf_first`  in  $clog2(NUM_RF)  first RF index for op 11
- `cmd_len`  in  LENW  beats in burst minus 1
- `in_valid` / `in_ready`  in/out  1  payload handshake
- `in_data`  in  DATAW  payload
- `m_axis_tvalid` / `m_axis_tready`  out/in  1  toward MVM rx
- `m_axis_tdata`  out  DATAW  payload
- `m_axis_tuser`  out  USERW  encoded side-band
- `m_axis_tlast`  out  1  constant 1 on every valid beat
- `res_seen`  in  1  MVM tx valid&&ready, one pulse per released result
- `busy`  out  1  state != IDLE or output register full
- `pending`  out  PENDW  results expected but not yet seen
- `err_underflow`  out  1  sticky; result seen while `pending == 0`

## Operation
- FSM states: IDLE, BURST.
- IDLE: `cmd_ready = 1`. On a command handshake, latch op, node, RF index and length; clear the beat counter; go to BURST.
- BURST: `cmd_ready = 0`; `in_ready = !m_axis_tvalid || m_axis_tready`. On each payload handshake, load the output register:
  - `tdata = in_data`
  - `tuser[NODESW-1:0] = node`
  - `tuser[10:9] = op`
  - op 11: RF select is one-hot at the current RF index; all other `tuser` bits are 0.
  - Other ops: RF select is all zero.
- After each op-11 beat, the RF index increments and wraps from NUM_RF-1 to 0.
- When the beat counter equals `cmd_len` on a handshake, return to IDLE. A new command is accepted the next cycle, while the last beat may still sit in the output register.
- Pending counter: increments when an op-00 beat is accepted by the MVM (`m_axis_tvalid && m_axis_tready`) with `tdata[2]` (RLS) = 1. Decrements on `res_seen`.
  - Increment and decrement in the same cycle: counter unchanged.
  - Decrement at 0: counter stays 0 and `err_underflow` is set.
  - Increment at max: counter saturates.
- Reset at any time, including mid-burst:
  - FSM returns to IDLE.
  - Output register invalidated; the partial burst is dropped.
  - `pending` and `err_underflow` cleared.

## Timing
- Reset values: `cmd_ready = 1`, `in_ready = 0`, `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `m_axis_tuser = 0`, `m_axis_tlast = 0`, `busy = 0`, `pending = 0`, `err_underflow = 0`.
- Latency: payload accepted in cycle N appears on `m_axis_*` in cycle N+1. Full throughput is one beat per cycle while `m_axis_tready` stays high.
- Once `m_axis_tvalid` is asserted, `tdata` and `tuser` stay stable until `tready` is seen.
- `in_ready` is a combinational function of `m_axis_tready`. No other input-to-output combinational paths.
- The first payload handshake is possible in the cycle after the command handshake.

## Structure
- Shared package `mvm_pkg`:
  - op encodings `OP_INSTR`, `OP_RED`, `OP_INVEC`, `OP_RFW`
  - `TUSER_OP_LSB = 9`
  - `RF_BASE` default
  - instruction bit positions RDC/ACM/RLS/LST
  - state enum
- Sub-module `mvm_tuser_enc` (combinational): builds `tuser` from op, node and RF index. Reused by the result-side router later.

## Test plan
- RF write, `cmd_rf_first = 0`, `cmd_len = 63`, 64 payloads, tready = 1 → 64 consecutive beats:
  - `tuser[8:0] = 9'h1`, `tuser[10:9] = 2'b11`
  - one-hot advancing bit 11 → 74
  - `tlast = 1`; FSM back in IDLE after the 64th beat.
- RF write, `cmd_rf_first = 62`, `cmd_len = 3` → one-hot at bits 73, 74, 11, 12 (wrap).
- Input vector (op 10, payload of all `8'h01`), then reduction vector (op 01, all `8'h02`) → RF select = 0, `tuser[10:9]` = 10 then 01.
- Instruction with `tdata[31:0] = 32'h8000200E` (RLS = 1) → `pending = 1`. Then `res_seen` pulse → `pending = 0`. Second `res_seen` pulse → `err_underflow = 1`.
- `m_axis_tready` toggled 1,0,0,1 during a 4-beat burst → no beat lost or duplicated; data held stable while stalled.
- `rst_n` asserted after beat 2 of an 8-beat burst → all outputs at reset values immediately. A new command completes normally after release.
